// File: rtl/key_word_loader_pkg.sv
// Shared definitions for the key-entry word loader that feeds the asynchronous FIFO write side.
package key_word_loader_pkg;

  localparam int unsigned KWL_DATA_WIDTH = 8;
  localparam int unsigned KWL_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_FULL = 2'd1,
    WRITE     = 2'd2
  } kwl_state_e;

endpackage

// File: rtl/key_word_loader.sv
// Assembles a word LSB-first from debounced key pulses and writes it to the FIFO on commit,
// holding the word while the FIFO reports full.
module key_word_loader
  import key_word_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KWL_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = KWL_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit1_pulse,
  input  logic                  bit0_pulse,
  input  logic                  commit_pulse,
  input  logic                  clear_pulse,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic                  busy,
  output logic [7:0]            word_cnt,
  output logic                  drop_err
);

  kwl_state_e state;

  logic                  bit_any;
  logic                  bit_both;
  logic                  at_cap;
  logic [DATA_WIDTH-1:0] bit_mask;

  always_comb begin
    bit_any  = bit1_pulse | bit0_pulse;
    bit_both = bit1_pulse & bit0_pulse;
    at_cap   = (bit_cnt == CNT_WIDTH'(DATA_WIDTH));
    bit_mask = DATA_WIDTH'(1) << bit_cnt;
  end

  // Unentered bits are already 0, so a 0 entry only advances the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      wr_data  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (clear_pulse) begin
            wr_data <= '0;
            bit_cnt <= '0;
          end else if (commit_pulse && (bit_cnt != '0)) begin
            busy <= 1'b1;
            if (!full) begin
              state <= WRITE;
              wr_en <= 1'b1;
            end else begin
              state <= WAIT_FULL;
            end
          end else if (bit_both) begin
            drop_err <= 1'b1;
          end else if (bit_any) begin
            if (at_cap) begin
              drop_err <= 1'b1;
            end else begin
              if (bit1_pulse) wr_data <= wr_data | bit_mask;
              bit_cnt <= bit_cnt + CNT_WIDTH'(1);
            end
          end
        end

        WAIT_FULL: begin
          if (bit_any) drop_err <= 1'b1;
          if (clear_pulse) begin
            state   <= FILL;
            busy    <= 1'b0;
            wr_data <= '0;
            bit_cnt <= '0;
          end else if (!full) begin
            state <= WRITE;
            wr_en <= 1'b1;
          end
        end

        WRITE: begin
          if (bit_any) drop_err <= 1'b1;
          state    <= FILL;
          wr_en    <= 1'b0;
          busy     <= 1'b0;
          wr_data  <= '0;
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 8'd1;
        end

        default: begin
          state <= FILL;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
